// File: rtl/poly_mem_writer.sv
// Streams one polynomial of N_COEFF coefficients into the coefficient memory at
// addresses 0..N_COEFF-1 and tracks the highest index that holds a nonzero value.
module poly_mem_writer #(
    parameter int RAM_WIDTH     = 26,
    parameter int RAM_ADDR_BITS = 11,
    parameter int N_COEFF       = 757
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RAM_WIDTH-1:0]     in_data,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] write_address,
    output logic [RAM_WIDTH-1:0]     input_data,
    output logic [RAM_ADDR_BITS-1:0] deg,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(N_COEFF - 1);

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [RAM_ADDR_BITS-1:0] deg_q, deg_d;
    logic [RAM_WIDTH-1:0]     data_q, data_d;
    logic                     we_q, we_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            deg_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            deg_q   <= deg_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        deg_d    = deg_q;
        data_d   = data_q;
        we_d     = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    deg_d   = '0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    data_d = in_data;
                    if (|in_data) deg_d = idx_q;
                    // Index parks on the last slot instead of wrapping.
                    if (idx_q == LAST_IDX) state_d = S_DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                // The final write registered on the last beat is visible in this cycle.
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign write_enable  = we_q;
    assign write_address = addr_q;
    assign input_data    = data_q;
    assign deg           = deg_q;

endmodule

// File: tb/tb_poly_mem_writer.sv
// Scoreboard bench for poly_mem_writer: every accepted beat queues its expected
// memory write; a monitor pops and compares each write as it appears.
`timescale 1ns/1ps
module tb_poly_mem_writer;

    localparam int W = 26;
    localparam int A = 11;
    localparam int N = 757;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         write_enable;
    logic [A-1:0] write_address;
    logic [W-1:0] input_data;
    logic [A-1:0] deg;
    logic         busy;
    logic         done;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    poly_mem_writer #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .N_COEFF(N)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .write_enable(write_enable), .write_address(write_address),
        .input_data(input_data), .deg(deg), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each write must match the head of the scoreboard, in order and on time.
    always @(negedge clk) begin
        exp_t e;
        if (write_enable === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%0d data=%h, required no write", write_address, input_data);
            end else begin
                e = sb.pop_front();
                if (write_address !== e.addr || input_data !== e.data || cyc !== e.cyc) begin
                    fails++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             write_address, input_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            tests++;
            fails++;
            e = sb.pop_front();
            $display("FAIL missing_write got write_enable=%b, required write addr=%0d", write_enable, e.addr);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired, required completion");
        $fatal(1, "watchdog");
    end

    // mode: 0 data=index+1, 1 sparse, 2 random, 3 all zero. rst_at<0 / start_at<0 disable.
    task automatic run_load(input int mode, input bit gaps, input int start_at, input int rst_at,
                            input string nm, output int bcnt);
        int           k, j;
        bit           v;
        logic [W-1:0] d;
        logic [A-1:0] edeg;
        k = 0; j = 0; edeg = '0; bcnt = 0;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (deg !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_enter got deg=%0d busy=%b, required deg=0 busy=1", nm, deg, busy);
        end
        while (k < N) begin
            tests++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s_load k=%0d got ready=%b busy=%b done=%b, required 1 1 0", nm, k, in_ready, busy, done);
            end
            if (busy === 1'b1) bcnt++;
            if (k == rst_at) begin
                rst = 1'b1;
                in_valid = 1'b1;
                in_data = '1;
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                tests++;
                if (in_ready !== 1'b0 || write_enable !== 1'b0 || deg !== '0 || done !== 1'b0 ||
                    busy !== 1'b0 || write_address !== '0 || input_data !== '0) begin
                    fails++;
                    $display("FAIL %s_rst got ready=%b we=%b deg=%0d done=%b busy=%b addr=%0d, required all 0",
                             nm, in_ready, write_enable, deg, done, busy, write_address);
                end
                @(negedge clk);
                tests++;
                if (done !== 1'b0 || busy !== 1'b0 || write_enable !== 1'b0 || sb.size() != 0) begin
                    fails++;
                    $display("FAIL %s_post_rst got done=%b busy=%b we=%b pending=%0d, required 0 0 0 0",
                             nm, done, busy, write_enable, sb.size());
                end
                sb.delete();
                return;
            end
            v = gaps ? ((j % 4 == 0) || (j % 4 == 3)) : 1'b1;
            case (mode)
                0:       d = W'(k + 1);
                1:       d = (k == 5) ? 26'h1 : ((k == 300) ? 26'h3FFFFFF : '0);
                2:       d = W'($urandom);
                default: d = '0;
            endcase
            start = (k == start_at);
            in_valid = v;
            in_data = v ? d : W'($urandom);
            if (v) begin
                sb.push_back('{A'(k), d, cyc + 1});
                if (|d) edeg = A'(k);
                k++;
            end
            j++;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || write_enable !== 1'b1 || write_address !== A'(N - 1) ||
            deg !== edeg || busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_done got done=%b we=%b addr=%0d deg=%0d busy=%b ready=%b, required 1 1 %0d %0d 1 0",
                     nm, done, write_enable, write_address, deg, busy, in_ready, N - 1, edeg);
        end
        if (busy === 1'b1) bcnt++;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || write_enable !== 1'b0 || deg !== edeg) begin
                fails++;
                $display("FAIL %s_idle got done=%b busy=%b ready=%b we=%b deg=%0d, required 0 0 0 0 deg=%0d",
                         nm, done, busy, in_ready, write_enable, deg, edeg);
            end
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_leftover got %0d pending writes, required 0", nm, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            write_address !== '0 || input_data !== '0 || deg !== '0) begin
            fails++;
            $display("FAIL reset_state got ready=%b we=%b busy=%b done=%b addr=%0d data=%h deg=%0d, required all 0",
                     in_ready, write_enable, busy, done, write_address, input_data, deg);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 26'h155;
        repeat (10) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || write_enable !== 1'b0 || deg !== '0 || done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle got ready=%b we=%b deg=%0d done=%b busy=%b, required all 0",
                         in_ready, write_enable, deg, done, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_rate();
        int b;
        run_load(0, 1'b0, -1, -1, "full", b);
        tests++;
        if (b !== N + 1) begin
            fails++;
            $display("FAIL full_busy_cycles got %0d, required %0d", b, N + 1);
        end
    endtask

    task automatic test_sparse();
        int b;
        run_load(1, 1'b0, -1, -1, "sparse", b);
    endtask

    task automatic test_backpressure();
        int b;
        run_load(2, 1'b1, -1, -1, "gaps", b);
    endtask

    task automatic test_zero_ignored_start();
        int b;
        run_load(3, 1'b0, 100, -1, "zero", b);
    endtask

    task automatic test_reset_midload();
        int b;
        run_load(0, 1'b0, -1, 400, "midrst", b);
        run_load(0, 1'b0, -1, -1, "reload", b);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_sparse();
        test_backpressure();
        test_zero_ignored_start();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
